leaky_relu_sched: RTL and testbench
===================================

Name: leaky_relu_sched

Overview:
Job controller for a bank of LANES leaky_relu_child units on the output side of the systolic array. It accepts a job of num_rows row vectors, each LANES x 16-bit signed, and skews each row onto the lanes diagonally, one lane per cycle. It feeds every lane the shared leak factor, collects the child results, deskews them back into full rows and signals completion. The leak factor is a configuration register that is frozen for the duration of a job.

Parameters:
LANES, 4, number of leaky_relu_child lanes driven (1..16)
ROW_W, 8, width of the row counter; max job = 2^ROW_W-1 rows

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cfg_we  in  1  write strobe for leak factor register
cfg_leak_factor  in  16  signed fixed-point leak factor
start  in  1  start job (sampled in IDLE only)
num_rows  in  ROW_W  job length, captured on start
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
in_valid  in  1  row available
in_ready  out  1  row accepted when in_valid && in_ready
in_data  in  16*LANES  row; lane i = bits [16i+15:16i]
lane_valid_out  out  LANES  to child lr_valid_in
lane_data_out  out  16*LANES  to child lr_data_in
leak_factor_out  out  16  to every child lr_leak_factor_in
lane_valid_in  in  LANES  from child lr_valid_out
lane_data_in  in  16*LANES  from child lr_data_out
out_valid  out  1  deskewed result row valid
out_data  out  16*LANES  result row
err  out  1  sticky lane-alignment error

Behaviour:
- Reset (rst_n=0, async): state IDLE. All outputs are 0: busy, done, in_ready, lane_valid_out, lane_data_out, leak_factor_out, out_valid, out_data and err. Row counters, skew and deskew pipes are cleared. Reset mid-job aborts the job and emits no done.
- Leak register: updated from cfg_leak_factor on cfg_we only when busy=0. cfg_we is ignored while busy. leak_factor_out always shows the register.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: on start, capture num_rows. If num_rows=0, go to DONE. Otherwise go to RUN and clear in_cnt and out_cnt.
  - RUN: in_ready=1. Each accept increments in_cnt. When an accept makes in_cnt==num_rows, go to DRAIN and drop in_ready in the next cycle.
  - DRAIN: in_ready=0. Go to DONE when out_cnt reaches num_rows; out_cnt counts out_valid cycles in both RUN and DRAIN.
  - DONE: done=1 for this single cycle, busy=0, then go to IDLE.
- busy=1 in RUN and DRAIN only. start is ignored outside IDLE.
- Skew: a row accepted in cycle t drives lane i at cycle t+1+i. At that cycle lane_valid_out[i]=1 and lane_data_out lane i = in_data lane i. Each lane data is held in a registered shift stage of depth i+1. When no row is present, lane_valid_out[i]=0 and lane data=0.
- Rows may be accepted back-to-back; in_valid gaps propagate as bubbles. No backpressure from the children; out has no ready.
- Deskew: lane i's return passes through LANES-1-i registers, then a common output register. Returns arrive at t+2+i, so all lanes align and out_valid=1 at t+LANES+2 (6 cycles for LANES=4).
- out_valid is taken from deskewed lane 0. out_data is 0 when out_valid=0.
- err: set and held until reset if the deskewed lane valids are not all equal in any cycle.
- Data is passed through unmodified; no arithmetic beyond the counters. Counter comparison is unsigned, ROW_W bits.
- Simultaneous events: an accept of the final row and the first out_valid may coincide; both counters update. cfg_we on the same cycle as start in IDLE: the write takes effect first, so the job uses the new factor.

Test Plan:
- Reset: apply rst_n=0 mid-RUN with 2 rows in flight -> all outputs go 0 asynchronously, state IDLE, no done, no further out_valid.
- Basic job, LANES=4, leak=0x0080 (0.5 Q8.8): start, num_rows=3; rows {0x0100,0xFE00,0x0000,0xFF00}, {0x0200,0x0200,0xFC00,0x0080}, {0xFF80,0x0100,0x0100,0x0100} back-to-back -> out rows {0x0100,0xFF00,0x0000,0xFF80}, {0x0200,0x0200,0xFE00,0x0080}, {0xFFC0,0x0100,0x0100,0x0100}. First out_valid 6 cycles after first accept. done pulses the cycle after the third out_valid.
- Bubbles: in_valid toggles 1,0,1 on a 2-row job -> out_valid pattern 1,0,1, in_ready=0 after the 2nd accept, done correct.
- num_rows=0: start -> busy never asserts, done=1 exactly 1 cycle after start, no lane activity.
- Config freeze: write leak=0x0040 during busy, then after done -> the job uses the old factor; the next job uses 0x0040. start pulses while busy are ignored.
- Alignment fault: bench forces child lane 2 valid one cycle late -> err=1 and held until reset.

Source files
------------

// File: rtl/leaky_relu_sched.sv
// Job controller for a bank of leaky_relu_child lanes: skews accepted rows diagonally
// onto the lanes, realigns the child returns into full rows and signals job completion.
module leaky_relu_sched #(
  parameter int LANES = 4,
  parameter int ROW_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [15:0]           cfg_leak_factor,
  input  logic                  start,
  input  logic [ROW_W-1:0]      num_rows,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*LANES-1:0]   in_data,
  output logic [LANES-1:0]      lane_valid_out,
  output logic [16*LANES-1:0]   lane_data_out,
  output logic [15:0]           leak_factor_out,
  input  logic [LANES-1:0]      lane_valid_in,
  input  logic [16*LANES-1:0]   lane_data_in,
  output logic                  out_valid,
  output logic [16*LANES-1:0]   out_data,
  output logic                  err
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state_q;
  logic [ROW_W-1:0]     num_q, in_cnt_q, out_cnt_q;
  logic [ROW_W-1:0]     in_cnt_inc, out_cnt_inc;
  logic                 busy_q, done_q, in_ready_q, out_valid_q, err_q;
  logic [16*LANES-1:0]  out_data_q;
  logic [15:0]          leak_q;
  logic                 accept;
  logic [LANES-1:0]     dsk_v;
  logic [16*LANES-1:0]  dsk_d;

  assign accept      = in_valid && in_ready_q;
  assign in_cnt_inc  = in_cnt_q + 1'b1;
  assign out_cnt_inc = out_cnt_q + ROW_W'(out_valid_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      num_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          num_q     <= num_rows;
          in_cnt_q  <= '0;
          out_cnt_q <= '0;
          if (num_rows == '0) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q    <= RUN;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          out_cnt_q <= out_cnt_inc;
          if (accept) begin
            in_cnt_q <= in_cnt_inc;
            if (in_cnt_inc == num_q) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        DRAIN: begin
          out_cnt_q <= out_cnt_inc;
          if (out_cnt_inc == num_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The leak factor is frozen while a job is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                leak_q <= '0;
    else if (cfg_we && !busy_q) leak_q <= cfg_leak_factor;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int K = LANES - 1 - gi;

    logic [gi:0] skv_q;
    logic [15:0] skd_q [0:gi];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skv_q <= '0;
        for (int j = 0; j <= gi; j++) skd_q[j] <= '0;
      end else begin
        skv_q[0] <= accept;
        skd_q[0] <= accept ? in_data[16*gi +: 16] : 16'h0000;
        for (int j = 1; j <= gi; j++) begin
          skv_q[j] <= skv_q[j-1];
          skd_q[j] <= skd_q[j-1];
        end
      end
    end

    assign lane_valid_out[gi]        = skv_q[gi];
    assign lane_data_out[16*gi +: 16] = skd_q[gi];

    // Later lanes return later, so they need fewer realignment stages.
    if (K == 0) begin : g_pass
      assign dsk_v[gi]          = lane_valid_in[gi];
      assign dsk_d[16*gi +: 16] = lane_data_in[16*gi +: 16];
    end else begin : g_dly
      logic [K-1:0] dv_q;
      logic [15:0]  dd_q [0:K-1];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dv_q <= '0;
          for (int j = 0; j < K; j++) dd_q[j] <= '0;
        end else begin
          dv_q[0] <= lane_valid_in[gi];
          dd_q[0] <= lane_data_in[16*gi +: 16];
          for (int j = 1; j < K; j++) begin
            dv_q[j] <= dv_q[j-1];
            dd_q[j] <= dd_q[j-1];
          end
        end
      end

      assign dsk_v[gi]          = dv_q[K-1];
      assign dsk_d[16*gi +: 16] = dd_q[K-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      out_valid_q <= dsk_v[0];
      out_data_q  <= dsk_v[0] ? dsk_d : '0;
      if (dsk_v != {LANES{dsk_v[0]}}) err_q <= 1'b1;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign in_ready        = in_ready_q;
  assign leak_factor_out = leak_q;
  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign err             = err_q;
endmodule

// File: tb/tb_leaky_relu_sched.sv
// Scoreboard bench for leaky_relu_sched: models the child lanes, predicts each result row
// from the accepted input row and the leak factor in force, and checks job control.
module tb_leaky_relu_sched;
  localparam int LANES = 4;
  localparam int ROW_W = 8;
  localparam int DW    = 16*LANES;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cfg_we;
  logic [15:0]      cfg_leak_factor;
  logic             start;
  logic [ROW_W-1:0] num_rows;
  logic             busy, done, in_valid, in_ready;
  logic [DW-1:0]    in_data;
  logic [LANES-1:0] lane_valid_out, lane_valid_in;
  logic [DW-1:0]    lane_data_out, lane_data_in;
  logic [15:0]      leak_factor_out;
  logic             out_valid, err;
  logic [DW-1:0]    out_data;

  leaky_relu_sched #(.LANES(LANES), .ROW_W(ROW_W)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_leak_factor(cfg_leak_factor),
    .start(start), .num_rows(num_rows), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .lane_valid_out(lane_valid_out), .lane_data_out(lane_data_out),
    .leak_factor_out(leak_factor_out), .lane_valid_in(lane_valid_in),
    .lane_data_in(lane_data_in), .out_valid(out_valid), .out_data(out_data), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_acc, first_ov, last_ov, ov_cnt;
  bit check_en = 1'b1;
  bit fault = 1'b0;
  logic [15:0] model_leak = 16'h0000;
  logic [DW-1:0] sb [$];
  logic [DW-1:0] row_tab [0:15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Leaky ReLU on a Q8.8 value: positives pass, negatives scale by k/256.
  function automatic logic [15:0] lrelu(input logic [15:0] x, input logic [15:0] k);
    int p;
    if (!x[15]) return x;
    p = int'($signed(x)) * int'($signed(k));
    return 16'(p >>> 8);
  endfunction

  function automatic logic [DW-1:0] row_model(input logic [DW-1:0] r, input logic [15:0] k);
    logic [DW-1:0] o;
    o = '0;
    for (int i = 0; i < LANES; i++) o[16*i +: 16] = lrelu(r[16*i +: 16], k);
    return o;
  endfunction

  // Child lanes: one-cycle registered leaky ReLU; fault mode delays lane 2 one extra cycle.
  logic [LANES-1:0] ch_v;
  logic [DW-1:0]    ch_d;
  logic             late_v;
  logic [15:0]      late_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_v <= '0; ch_d <= '0; late_v <= 1'b0; late_d <= '0;
    end else begin
      ch_v <= lane_valid_out;
      for (int i = 0; i < LANES; i++)
        ch_d[16*i +: 16] <= lrelu(lane_data_out[16*i +: 16], leak_factor_out);
      late_v <= ch_v[2];
      late_d <= ch_d[47:32];
    end
  end

  always_comb begin
    lane_valid_in = ch_v;
    lane_data_in  = ch_d;
    if (fault) begin
      lane_valid_in[2]    = late_v;
      lane_data_in[47:32] = late_d;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus side: every accepted row pushes its predicted result.
  always @(negedge clk) begin
    if (rst_n && in_valid && in_ready) begin
      sb.push_back(row_model(in_data, model_leak));
      if (first_acc < 0) first_acc = cyc;
    end
  end

  // Monitor side: pops on every out_valid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        ov_cnt++;
        last_ov = cyc;
        if (first_ov < 0) first_ov = cyc;
        if (check_en) begin
          chk("out_expected", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) chk("out_data", out_data, sb.pop_front());
        end
      end else begin
        chk("out_data_idle", out_data, 64'd0);
      end
    end
  end

  task automatic idle_write(input logic [15:0] v);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_leak_factor = v;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_leak = v;
    chk("leak_write", leak_factor_out, v);
  endtask

  task automatic start_job(input int n, input bit with_cfg, input logic [15:0] cv);
    @(posedge clk); #1;
    start = 1'b1; num_rows = ROW_W'(n);
    if (with_cfg) begin cfg_we = 1'b1; cfg_leak_factor = cv; end
    first_acc = -1; first_ov = -1; last_ov = -1; ov_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    if (with_cfg) model_leak = cv;
  endtask

  // gap_mode: 0 back-to-back, 1 one bubble between rows, 2 random bubbles
  task automatic feed(input int n, input int gap_mode, input bit chk_ready);
    bit acc;
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1; in_data = row_tab[k];
      acc = 1'b0;
      for (int w = 0; w < 50 && !acc; w++) begin
        @(negedge clk); acc = in_ready;
        @(posedge clk); #1;
      end
      chk("accept_in_time", 64'(acc), 64'd1);
      in_valid = 1'b0; in_data = '0;
      if (k < n-1 && (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 1) == 1))) begin
        @(posedge clk); #1;
      end
    end
    if (chk_ready) begin
      @(negedge clk);
      chk("in_ready_after_last", 64'(in_ready), 64'd0);
    end
  endtask

  task automatic wait_done(input int n);
    bit seen = 1'b0;
    for (int w = 0; w < 200 && !seen; w++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("done_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("done_after_last_out", 64'(cyc), 64'(last_ov + 1));
      chk("rows_out", 64'(ov_cnt), 64'(n));
      chk("busy_at_done", 64'(busy), 64'd0);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
    end
  endtask

  task automatic random_rows(input int n);
    for (int k = 0; k < n; k++) row_tab[k] = {$urandom, $urandom};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, dcnt, vcnt;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_leak_factor = '0; start = 1'b0; num_rows = '0;
    in_valid = 1'b0; in_data = '0;
    first_acc = -1; first_ov = -1; last_ov = -1; ov_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_leak", leak_factor_out, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;

    // Basic 3-row job at leak 0.5
    idle_write(16'h0080);
    row_tab[0] = {16'hFF00, 16'h0000, 16'hFE00, 16'h0100};
    row_tab[1] = {16'h0080, 16'hFC00, 16'h0200, 16'h0200};
    row_tab[2] = {16'h0100, 16'h0100, 16'h0100, 16'hFF80};
    start_job(3, 1'b0, 16'h0);
    chk("busy_in_run", 64'(busy), 64'd1);
    feed(3, 0, 1'b1);
    wait_done(3);
    chk("first_latency", 64'(first_ov - first_acc), 64'(LANES + 2));

    // Bubbles: 1,0,1 on a 2-row job
    random_rows(2);
    start_job(2, 1'b0, 16'h0);
    feed(2, 1, 1'b1);
    wait_done(2);
    chk("bubble_spacing", 64'(last_ov - first_ov), 64'd2);

    // Zero-length job
    start_job(0, 1'b0, 16'h0);
    @(negedge clk);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    chk("zero_lanes", 64'(lane_valid_out), 64'd0);
    @(negedge clk);
    chk("zero_done_pulse", 64'(done), 64'd0);
    chk("zero_busy_after", 64'(busy), 64'd0);

    // Config freeze: write and start attempts while busy are ignored
    random_rows(3);
    start_job(3, 1'b0, 16'h0);
    feed(3, 0, 1'b0);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_leak_factor = 16'h0040; start = 1'b1; num_rows = 8'd5;
    @(posedge clk); #1;
    cfg_we = 1'b0; start = 1'b0;
    chk("leak_frozen", leak_factor_out, 64'h0080);
    wait_done(3);
    chk("start_ignored_busy", 64'(busy), 64'd0);

    // New factor written on the same cycle as start applies to that job
    random_rows(4);
    start_job(4, 1'b1, 16'h0040);
    chk("leak_with_start", leak_factor_out, 64'h0040);
    feed(4, 0, 1'b1);
    wait_done(4);

    // Random jobs
    for (int j = 0; j < 4; j++) begin
      n = $urandom_range(1, 8);
      random_rows(n);
      if (j == 2) idle_write(16'($urandom));
      start_job(n, 1'b0, 16'h0);
      feed(n, 2, 1'b1);
      wait_done(n);
    end
    chk("err_clean", 64'(err), 64'd0);

    // Reset mid-RUN with two rows in flight
    random_rows(4);
    start_job(4, 1'b0, 16'h0);
    feed(2, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    chk("arst_lane_valid", 64'(lane_valid_out), 64'd0);
    chk("arst_lane_data", lane_data_out, 64'd0);
    chk("arst_leak", leak_factor_out, 64'd0);
    chk("arst_out", {63'd0, out_valid} | out_data, 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    sb.delete();
    model_leak = 16'h0000;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dcnt = 0; vcnt = 0;
    for (int w = 0; w < 15; w++) begin
      @(negedge clk);
      dcnt += int'(done);
      vcnt += int'(out_valid);
    end
    chk("post_rst_no_done", 64'(dcnt), 64'd0);
    chk("post_rst_no_out", 64'(vcnt), 64'd0);

    // Alignment fault on lane 2
    chk("err_before_fault", 64'(err), 64'd0);
    check_en = 1'b0;
    fault = 1'b1;
    random_rows(2);
    start_job(2, 1'b0, 16'h0);
    feed(2, 0, 1'b0);
    repeat (12) @(negedge clk);
    chk("err_set", 64'(err), 64'd1);
    repeat (10) @(negedge clk);
    chk("err_held", 64'(err), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("err_cleared", 64'(err), 64'd0);
    fault = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_en = 1'b1;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
